// File: rtl/mem_miss_arbiter_pkg.sv
// ============================================================================
//  mem_miss_arbiter_pkg
//  Shared types for the I$/D$ miss arbiter and its memory-side interface.
//  Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

package mem_miss_arbiter_pkg;

    // Request payload carried from a cache miss to the memory hierarchy.
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  txn_id;
    } memory_request_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic MEM_ID_ICACHE = 1'b0;
    localparam logic MEM_ID_DCACHE = 1'b1;

    // Two-way round-robin: D$ wins when it is the only eligible requester,
    // or when both are eligible and I$ was granted last.
    function automatic logic rr_pick_dcache(input logic elig_i,
                                            input logic elig_d,
                                            input logic last_grant);
        return elig_d & (~elig_i | (last_grant == MEM_ID_ICACHE));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_miss_arbiter_if.sv
// ============================================================================
//  mem_miss_arbiter_if
//  Memory-side request/response bus between the miss arbiter and memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_miss_arbiter_if;
    import mem_miss_arbiter_pkg::*;

    logic                           mem_req_valid;
    memory_request_t                mem_req_info;
    logic                           mem_req_ready;
    logic                           mem_rsp_valid;
    logic [`DCACHE_LINE_WIDTH-1:0]  mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_info,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_info,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/mem_miss_arbiter.sv
// ============================================================================
//  mem_miss_arbiter
//  Round-robin sharing of one memory port between I$ and D$ misses, one
//  outstanding transaction, with a sticky response watchdog.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_miss_arbiter
    import mem_miss_arbiter_pkg::*;
#(
    parameter int MEM_TIMEOUT = 1024,
    parameter int TMO_WIDTH   = 11
) (
    input  wire logic                           clock,
    input  wire logic                           reset,
    input  wire logic                           icache_req_valid,
    input  memory_request_t                     icache_req_info,
    input  wire logic                           dcache_req_valid,
    input  memory_request_t                     dcache_req_info,
    mem_miss_arbiter_if.master                  mem,
    output logic                                rsp_valid_miss,
    output logic [`DCACHE_LINE_WIDTH-1:0]       rsp_data_miss,
    output logic                                rsp_cache_id,
    output logic                                timeout_err
);

    localparam logic [TMO_WIDTH-1:0] c_tmo_limit = TMO_WIDTH'(MEM_TIMEOUT);
    localparam logic [TMO_WIDTH-1:0] c_wdog_max  = '1;

    arb_state_t             r_state;
    logic                   r_last_grant;
    logic                   r_block_i;
    logic                   r_block_d;
    logic                   r_id;
    logic [TMO_WIDTH-1:0]   r_wdog;

    logic                   w_elig_i;
    logic                   w_elig_d;
    logic                   w_grant_any;
    logic                   w_grant_d;
    logic [TMO_WIDTH-1:0]   w_wdog_next;
    logic                   w_tmo_hit;

    always_comb begin
        w_elig_i    = icache_req_valid & ~r_block_i;
        w_elig_d    = dcache_req_valid & ~r_block_d;
        w_grant_any = w_elig_i | w_elig_d;
        w_grant_d   = rr_pick_dcache(w_elig_i, w_elig_d, r_last_grant);
        w_wdog_next = (r_wdog == c_wdog_max) ? r_wdog : r_wdog + 1'b1;
    end

    if (MEM_TIMEOUT != 0) begin : g_wdog_on
        assign w_tmo_hit = (w_wdog_next == c_tmo_limit);
    end else begin : g_wdog_off
        assign w_tmo_hit = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= IDLE;
            r_last_grant      <= MEM_ID_ICACHE;
            r_block_i         <= 1'b0;
            r_block_d         <= 1'b0;
            r_id              <= MEM_ID_ICACHE;
            r_wdog            <= '0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_info  <= '0;
            rsp_valid_miss    <= 1'b0;
            rsp_data_miss     <= '0;
            rsp_cache_id      <= MEM_ID_ICACHE;
            timeout_err       <= 1'b0;
        end else begin
            rsp_valid_miss <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // The mask only needs to cover one IDLE cycle after a response.
                    r_block_i <= 1'b0;
                    r_block_d <= 1'b0;
                    if (w_grant_any) begin
                        mem.mem_req_info  <= w_grant_d ? dcache_req_info : icache_req_info;
                        r_id              <= w_grant_d;
                        r_last_grant      <= w_grant_d;
                        mem.mem_req_valid <= 1'b1;
                        r_state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem.mem_req_ready) begin
                        mem.mem_req_valid <= 1'b0;
                        r_state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        rsp_data_miss  <= mem.mem_rsp_data;
                        rsp_cache_id   <= r_id;
                        rsp_valid_miss <= 1'b1;
                        r_wdog         <= '0;
                        r_state        <= RESP;
                    end else begin
                        r_wdog <= w_wdog_next;
                        if (w_tmo_hit) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (r_id == MEM_ID_DCACHE) begin
                        r_block_d <= 1'b1;
                    end else begin
                        r_block_i <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_miss_arbiter.sv
// ============================================================================
//  tb_mem_miss_arbiter
//  Directed and randomized checks of the miss arbiter against a transaction model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_miss_arbiter;
    import mem_miss_arbiter_pkg::*;

    localparam int LW = `DCACHE_LINE_WIDTH;

    logic              clock = 1'b0;
    logic              reset;
    logic              icache_req_valid;
    memory_request_t   icache_req_info;
    logic              dcache_req_valid;
    memory_request_t   dcache_req_info;
    logic              rsp_valid_miss;
    logic [LW-1:0]     rsp_data_miss;
    logic              rsp_cache_id;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_miss_arbiter_if mem_bus();

    mem_miss_arbiter #(
        .MEM_TIMEOUT (8),
        .TMO_WIDTH   (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .icache_req_valid (icache_req_valid),
        .icache_req_info  (icache_req_info),
        .dcache_req_valid (dcache_req_valid),
        .dcache_req_info  (dcache_req_info),
        .mem              (mem_bus.master),
        .rsp_valid_miss   (rsp_valid_miss),
        .rsp_data_miss    (rsp_data_miss),
        .rsp_cache_id     (rsp_cache_id),
        .timeout_err      (timeout_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic memory_request_t rand_req();
        memory_request_t r;
        r.addr   = $urandom;
        r.txn_id = 8'($urandom);
        return r;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        reset                 = 1'b1;
        icache_req_valid      = 1'b0;
        dcache_req_valid      = 1'b0;
        icache_req_info       = '0;
        dcache_req_info       = '0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_valid"}, LW'(mem_bus.mem_req_valid), '0);
        check({tag, "_req_info"},  LW'(mem_bus.mem_req_info),  '0);
        check({tag, "_rsp_valid"}, LW'(rsp_valid_miss),        '0);
        check({tag, "_rsp_data"},  rsp_data_miss,              '0);
        check({tag, "_rsp_id"},    LW'(rsp_cache_id),          '0);
        check({tag, "_timeout"},   LW'(timeout_err),           '0);
    endtask

    // Plays the memory for one transaction: waits for the issue, optionally
    // stalls ready, responds after lat WAIT cycles, and checks the cache-side return.
    task automatic serve(input string tag, input logic exp_id, input memory_request_t exp_info,
                         input int rdy_lo, input int lat, input logic [LW-1:0] data,
                         input bit spur, output int waited);
        waited = 0;
        mem_bus.mem_req_ready = 1'b0;
        for (int k = 1; k <= 12 && waited == 0; k++) begin
            tick();
            if (mem_bus.mem_req_valid === 1'b1) waited = k;
        end
        check({tag, "_issued"}, LW'(waited != 0), LW'(1'b1));
        check({tag, "_info"}, LW'(mem_bus.mem_req_info), LW'(exp_info));
        for (int k = 0; k < rdy_lo; k++) begin
            mem_bus.mem_rsp_valid = spur && (k == 0);
            tick();
            mem_bus.mem_rsp_valid = 1'b0;
            check({tag, "_hold_valid"}, LW'(mem_bus.mem_req_valid), LW'(1'b1));
            check({tag, "_hold_info"},  LW'(mem_bus.mem_req_info),  LW'(exp_info));
        end
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        check({tag, "_one_xfer"}, LW'(mem_bus.mem_req_valid), '0);
        repeat (lat - 1) tick();
        check({tag, "_no_early_rsp"}, LW'(rsp_valid_miss), '0);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = data;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check({tag, "_rsp_valid"}, LW'(rsp_valid_miss), LW'(1'b1));
        check({tag, "_rsp_id"},    LW'(rsp_cache_id),   LW'(exp_id));
        check({tag, "_rsp_data"},  rsp_data_miss,       data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int              w;
        memory_request_t pi;
        memory_request_t pd;
        logic [LW-1:0]   d5;
        logic [LW-1:0]   a5;
        logic            last_m;
        logic            pend [2];
        memory_request_t pay  [2];

        do_reset();
        check_reset_state("reset");

        // Single I$ miss, ready high, response 3 cycles after issue.
        a5 = {(LW / 8){8'hA5}};
        pi = rand_req();
        icache_req_info  = pi;
        icache_req_valid = 1'b1;
        serve("t1", MEM_ID_ICACHE, pi, 0, 3, a5, 1'b0, w);
        check("t1_latency", LW'(w), LW'(1));
        icache_req_valid = 1'b0;

        // Simultaneous requests after reset: D$ first, I$ in the first free IDLE cycle.
        do_reset();
        pi = rand_req();
        pd = rand_req();
        icache_req_info  = pi;
        dcache_req_info  = pd;
        icache_req_valid = 1'b1;
        dcache_req_valid = 1'b1;
        serve("t2_d", MEM_ID_DCACHE, pd, 0, 2, rand_line(), 1'b0, w);
        check("t2_d_latency", LW'(w), LW'(1));
        dcache_req_valid = 1'b0;
        serve("t2_i", MEM_ID_ICACHE, pi, 0, 2, rand_line(), 1'b0, w);
        check("t2_i_latency", LW'(w), LW'(2));
        icache_req_valid = 1'b0;

        // Both held high for four transactions: strict alternation.
        do_reset();
        last_m = MEM_ID_ICACHE;
        pay[0] = rand_req();
        pay[1] = rand_req();
        icache_req_info  = pay[0];
        dcache_req_info  = pay[1];
        icache_req_valid = 1'b1;
        dcache_req_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            logic win;
            win = ~last_m;
            serve("t3", win, pay[win], 0, 2, rand_line(), 1'b0, w);
            check("t3_latency", LW'(w), LW'((n == 0) ? 1 : 2));
            last_m   = win;
            pay[win] = rand_req();
            icache_req_info = pay[0];
            dcache_req_info = pay[1];
        end
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;

        // Ready stalled 5 cycles with a stray response pulse inside ISSUE.
        do_reset();
        pi = rand_req();
        icache_req_info  = pi;
        icache_req_valid = 1'b1;
        serve("t4", MEM_ID_ICACHE, pi, 5, 4, rand_line(), 1'b1, w);
        icache_req_valid = 1'b0;

        // D$ valid dropped one cycle late must not re-grant.
        do_reset();
        pd = rand_req();
        d5 = rand_line();
        dcache_req_info  = pd;
        dcache_req_valid = 1'b1;
        serve("t5", MEM_ID_DCACHE, pd, 0, 2, d5, 1'b0, w);
        tick();
        dcache_req_valid = 1'b0;
        check("t5_idle_no_req", LW'(mem_bus.mem_req_valid), '0);
        tick();
        check("t5_no_regrant", LW'(mem_bus.mem_req_valid), '0);

        // Stray response while IDLE is ignored and outputs hold.
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = rand_line();
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check("t6_no_rsp", LW'(rsp_valid_miss), '0);
        check("t6_data_hold", rsp_data_miss, d5);
        check("t6_id_hold", LW'(rsp_cache_id), LW'(MEM_ID_DCACHE));
        tick();
        check("t6_no_rsp_late", LW'(rsp_valid_miss), '0);
        pi = rand_req();
        icache_req_info  = pi;
        icache_req_valid = 1'b1;
        serve("t6_after", MEM_ID_ICACHE, pi, 0, 1, rand_line(), 1'b0, w);
        check("t6_after_latency", LW'(w), LW'(1));
        icache_req_valid = 1'b0;

        // Randomized traffic against the round-robin transaction model.
        do_reset();
        last_m  = MEM_ID_ICACHE;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 16; t++) begin
            logic win;
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    pay[k]  = rand_req();
                end
            end
            if (!pend[0] && !pend[1]) begin
                int j;
                j = $urandom_range(0, 1);
                pend[j] = 1'b1;
                pay[j]  = rand_req();
            end
            icache_req_valid = pend[0];
            icache_req_info  = pay[0];
            dcache_req_valid = pend[1];
            dcache_req_info  = pay[1];
            win = (pend[0] && pend[1]) ? ~last_m : pend[1];
            serve("rnd", win, pay[win], $urandom_range(0, 3), $urandom_range(1, 6),
                  rand_line(), 1'($urandom_range(0, 1)), w);
            last_m    = win;
            pend[win] = 1'b0;
            icache_req_valid = pend[0];
            dcache_req_valid = pend[1];
        end
        check("rnd_no_timeout", LW'(timeout_err), '0);

        // Memory never responds: sticky watchdog, cleared only by reset.
        do_reset();
        pi = rand_req();
        icache_req_info  = pi;
        icache_req_valid = 1'b1;
        tick();
        check("t7_issue", LW'(mem_bus.mem_req_valid), LW'(1'b1));
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        repeat (7) tick();
        check("t7_tmo_before", LW'(timeout_err), '0);
        tick();
        check("t7_tmo_set", LW'(timeout_err), LW'(1'b1));
        repeat (5) tick();
        check("t7_tmo_sticky", LW'(timeout_err), LW'(1'b1));
        check("t7_no_rsp", LW'(rsp_valid_miss), '0);
        do_reset();
        check_reset_state("t7_reset");
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = rand_line();
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check("t7_aborted_rsp", LW'(rsp_valid_miss), '0);
        pd = rand_req();
        dcache_req_info  = pd;
        dcache_req_valid = 1'b1;
        serve("t7_after", MEM_ID_DCACHE, pd, 0, 2, rand_line(), 1'b0, w);
        check("t7_after_latency", LW'(w), LW'(1));
        dcache_req_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
